mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction memory depth in 16-bit words.
REQ-002 SHALL have parameter DMEM_BYTES, default 256, meaning data memory depth in bytes.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port PC  input  8  instruction fetch address from the CPU.
REQ-006 SHALL have port Instr  output  16  instruction word returned to the CPU.
REQ-007 SHALL have port DataAdr  input  8  data address from the CPU.
REQ-008 SHALL have port WriteData  input  8  store data from the CPU.
REQ-009 SHALL have port MemWrite  input  1  store strobe from the CPU.
REQ-010 SHALL have port ReadData  output  8  load data returned to the CPU.
REQ-011 SHALL have port load_valid  input  1  boot byte available.
REQ-012 SHALL have port load_ready  output  1  boot byte accepted when high with load_valid.
REQ-013 SHALL have port load_byte  input  8  boot byte payload.
REQ-014 SHALL have port load_last  input  1  marks final boot byte.
REQ-015 SHALL have port reload  input  1  single-cycle request to re-enter boot load from RUN.
REQ-016 SHALL have port cpu_reset  output  1  holds the CPU in reset while not in RUN.
REQ-017 SHALL have port loaded  output  1  high in RUN.

Function
REQ-018 SHALL implement FSM states LOAD_LO, LOAD_HI, RUN.
REQ-019 SHALL assert load_ready in LOAD_LO and LOAD_HI only; accept = load_valid && load_ready.
REQ-020 SHALL, on accept in LOAD_LO, latch load_byte as low byte and go to LOAD_HI, or, if load_last, write {8'h00, byte} to imem[waddr] and go to RUN.
REQ-021 SHALL, on accept in LOAD_HI, write {load_byte, low} to imem[waddr], increment waddr (8-bit), and go to LOAD_LO, or to RUN if load_last.
REQ-022 SHALL go to RUN after the write to waddr = IMEM_WORDS-1 even without load_last; waddr wraps to 0.
REQ-023 SHALL hold state while load_valid is low; no bytes lost or duplicated.
REQ-024 SHALL, on reload in RUN, go to LOAD_LO with waddr = 0; reload ignored in load states.
REQ-025 SHALL drive Instr = imem[PC] combinationally in RUN and 16'h0000 otherwise.
REQ-026 SHALL drive ReadData = dmem[DataAdr] combinationally (zero latency) in all states.
REQ-027 SHALL write dmem[DataAdr] <= WriteData on clk edge when MemWrite && RUN; MemWrite ignored in load states.
REQ-028 SHALL present the old dmem value on ReadData during the cycle of a same-address write; new value visible the next cycle.
REQ-029 SHALL register cpu_reset = (state != RUN) and loaded = (state == RUN); both change the cycle after the state transition edge.

Reset
REQ-030 SHALL, on reset, asynchronously set state = LOAD_LO, waddr = 0, low latch = 0, cpu_reset = 1, loaded = 0.
REQ-031 SHALL not clear imem or dmem contents on reset.
REQ-032 SHALL, on reset mid-load, discard a half-assembled word; reload starts at word 0.

Structure
REQ-033 SHALL take FSM state encoding and the 16-bit word/8-bit address width constants from the shared CPU package.
REQ-034 SHALL place the boot-byte assembler and FSM in a single sub-module boot_loader; memory arrays stay in mem_responder.

Verification
REQ-035 Bench SHALL load bytes 34,12,78,56(last) -> imem[0]=16'h1234, imem[1]=16'h5678, loaded=1 next cycle, Instr=16'h1234 at PC=0.
REQ-036 Bench SHALL send 3 bytes AA,BB,CC(last) -> imem[1]=16'h00CC, RUN entered.
REQ-037 Bench SHALL stream 512 bytes with load_last=0 -> RUN after 512th accept, waddr=0, byte 513 not accepted.
REQ-038 Bench SHALL, in RUN, write 8'h5A to DataAdr 8'h10 -> ReadData old value same cycle, 8'h5A next cycle; same store during load leaves dmem unchanged.
REQ-039 Bench SHALL assert reset after 1 byte of a load -> cpu_reset=1 immediately, next two bytes 11,22(last) written to imem[0]=16'h2211.
REQ-040 Bench SHALL pulse reload in RUN and toggle load_valid randomly -> load_ready=1 next cycle, Instr=0 until reload completes, no byte dropped.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared CPU package: boot FSM state encoding and the word/byte/address
// widths used by the memory responder and its boot loader.
package mem_responder_pkg;

    localparam int WORD_W = 16;   // instruction word width
    localparam int BYTE_W = 8;    // data / boot byte width
    localparam int ADDR_W = 8;    // CPU address width (PC, DataAdr, waddr)

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,           // waiting for low byte of the next word
        LOAD_HI = 2'd1,           // low byte held, waiting for high byte
        RUN     = 2'd2            // image loaded, CPU released
    } boot_state_t;

endpackage

// File: rtl/mem_responder_boot_loader.sv
// boot_loader: assembles little-endian byte pairs from the boot stream into
// 16-bit instruction words and sequences the LOAD_LO/LOAD_HI/RUN FSM.
// Ports:
//   clk, reset            clock, async active-high reset
//   load_valid/ready      boot byte handshake (ready only in load states)
//   load_byte, load_last  boot byte payload and end-of-image marker
//   reload                request to restart boot load from RUN
//   we, waddr, wdata      instruction memory write port
//   state                 current FSM state
//   cpu_reset, loaded     registered status derived from state
module boot_loader
    import mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              load_last,
    input  logic              reload,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output boot_state_t       state,
    output logic              cpu_reset,
    output logic              loaded
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(IMEM_WORDS - 1);

    boot_state_t       state_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [BYTE_W-1:0] low, low_n;
    logic              accept;

    assign load_ready = (state == LOAD_LO) || (state == LOAD_HI);
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD_LO;
            waddr     <= '0;
            low       <= '0;
            cpu_reset <= 1'b1;
            loaded    <= 1'b0;
        end else begin
            state     <= state_n;
            waddr     <= waddr_n;
            low       <= low_n;
            // Sampled from the pre-edge state, so these lag a transition by one cycle.
            cpu_reset <= (state != RUN);
            loaded    <= (state == RUN);
        end
    end

    always_comb begin
        state_n = state;
        waddr_n = waddr;
        low_n   = low;
        we      = 1'b0;
        wdata   = {8'h00, load_byte};
        case (state)
            LOAD_LO: begin
                if (accept) begin
                    if (load_last) begin
                        // Odd-length image: final word padded with a zero high byte.
                        we      = 1'b1;
                        state_n = RUN;
                    end else begin
                        low_n   = load_byte;
                        state_n = LOAD_HI;
                    end
                end
            end
            LOAD_HI: begin
                if (accept) begin
                    we    = 1'b1;
                    wdata = {load_byte, low};
                    if (waddr == LAST_WORD) begin
                        // Memory full: stop loading even without load_last.
                        waddr_n = '0;
                        state_n = RUN;
                    end else begin
                        waddr_n = waddr + 1'b1;
                        state_n = load_last ? RUN : LOAD_LO;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_n = LOAD_LO;
                    waddr_n = '0;
                    low_n   = '0;
                end
            end
            default: state_n = LOAD_LO;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: instruction and data memories for a small CPU, with the
// instruction image streamed in byte-wise by boot_loader before the CPU runs.
// Ports:
//   clk, reset                    clock, async active-high reset
//   PC / Instr                    instruction fetch (Instr is zero outside RUN)
//   DataAdr/WriteData/MemWrite    data store (only honoured in RUN)
//   ReadData                      zero-latency data load
//   load_valid/ready/byte/last    boot byte stream
//   reload                        restart boot load from RUN
//   cpu_reset, loaded             CPU hold and load-complete status
// Memory contents are not cleared by reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    output logic [WORD_W-1:0] Instr,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [BYTE_W-1:0] WriteData,
    input  logic              MemWrite,
    output logic [BYTE_W-1:0] ReadData,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [BYTE_W-1:0] load_byte,
    input  logic              load_last,
    input  logic              reload,
    output logic              cpu_reset,
    output logic              loaded
);

    logic [WORD_W-1:0] imem [IMEM_WORDS];
    logic [BYTE_W-1:0] dmem [DMEM_BYTES];

    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [WORD_W-1:0] imem_wdata;
    boot_state_t       state;

    boot_loader #(.IMEM_WORDS(IMEM_WORDS)) u_boot (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .reload     (reload),
        .we         (imem_we),
        .waddr      (imem_waddr),
        .wdata      (imem_wdata),
        .state      (state),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded)
    );

    always_ff @(posedge clk) begin
        if (imem_we)
            imem[imem_waddr] <= imem_wdata;
    end

    // Write-first is not wanted: ReadData shows the old byte during a store.
    always_ff @(posedge clk) begin
        if (MemWrite && (state == RUN))
            dmem[DataAdr] <= WriteData;
    end

    assign Instr    = (state == RUN) ? imem[PC] : '0;
    assign ReadData = dmem[DataAdr];

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] PC, DataAdr, WriteData, load_byte;
    logic       MemWrite, load_valid, load_last, reload;
    logic [15:0] Instr;
    logic [7:0]  ReadData;
    logic        load_ready, cpu_reset, loaded;

    int n_vec = 0;
    int n_err = 0;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (PC),
        .Instr      (Instr),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .ReadData   (ReadData),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .reload     (reload),
        .cpu_reset  (cpu_reset),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte, optionally after a random idle gap; returns once accepted.
    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                load_valid = 1'b0;
                chk("instr_zero_in_load", {16'h0, Instr}, 32'h0);
                tick();
            end
        end
        t = 0;
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        while (!load_ready && t < 50) begin
            tick();
            t++;
        end
        chk("byte_accept", {31'h0, (t < 50)}, 32'h1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
        PC = a;
        #1;
        chk(tag, {16'h0, Instr}, {16'h0, exp});
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        reset = 1'b1; PC = 8'h00; DataAdr = 8'h10; WriteData = 8'h00; MemWrite = 1'b0;
        load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0; reload = 1'b0;
        #1;
        chk("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        chk("rst_loaded",    {31'h0, loaded},    32'h0);
        chk("rst_ready",     {31'h0, load_ready}, 32'h1);
        chk("rst_instr",     {16'h0, Instr},     32'h0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Two-word image: little-endian byte pairs
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h78, 1'b0, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        chk("run_ready_low",   {31'h0, load_ready}, 32'h0);
        chk("loaded_lags",     {31'h0, loaded},     32'h0);
        tick();
        chk("loaded_next",     {31'h0, loaded},     32'h1);
        chk("cpu_reset_next",  {31'h0, cpu_reset},  32'h0);
        fetch("imem0_1234", 8'h00, 16'h1234);
        fetch("imem1_5678", 8'h01, 16'h5678);

        // Data store in RUN: old value during the write cycle, new value after
        DataAdr = 8'h10; WriteData = 8'h33; MemWrite = 1'b1;
        tick();
        chk("dmem_first",      {24'h0, ReadData}, 32'h33);
        WriteData = 8'h5A;
        #1;
        chk("dmem_old_same",   {24'h0, ReadData}, 32'h33);
        tick();
        MemWrite = 1'b0;
        chk("dmem_new_next",   {24'h0, ReadData}, 32'h5A);

        // Reload: ready immediately, cpu_reset one cycle later, stores ignored
        pulse_reload();
        chk("reload_ready",    {31'h0, load_ready}, 32'h1);
        chk("reload_instr0",   {16'h0, Instr},      32'h0);
        chk("reload_cpu_lag",  {31'h0, cpu_reset},  32'h0);
        WriteData = 8'h77; MemWrite = 1'b1;
        tick();
        chk("reload_cpu_rst",  {31'h0, cpu_reset},  32'h1);
        tick();
        MemWrite = 1'b0;
        chk("dmem_load_nowr",  {24'h0, ReadData},   32'h5A);

        // Odd-length image: last word zero-padded
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(8'hCC, 1'b1, 1'b0);
        chk("odd_run_ready",   {31'h0, load_ready}, 32'h0);
        tick();
        chk("odd_loaded",      {31'h0, loaded},     32'h1);
        fetch("odd_imem0",     8'h00, 16'hBBAA);
        fetch("odd_imem1",     8'h01, 16'h00CC);

        // Fill all 256 words without load_last; byte i carries value i[7:0]
        pulse_reload();
        for (int i = 0; i < 512; i++)
            send_byte(8'(i), 1'b0, 1'b0);
        chk("full_waddr_wrap", {24'h0, dut.u_boot.waddr}, 32'h0);
        load_valid = 1'b1; load_byte = 8'hEE;
        chk("byte513_ready",   {31'h0, load_ready}, 32'h0);
        tick();
        tick();
        load_valid = 1'b0;
        chk("full_loaded",     {31'h0, loaded},     32'h1);
        fetch("full_w0",       8'h00, 16'h0100);
        fetch("full_w5",       8'h05, 16'h0B0A);
        fetch("full_w255",     8'hFF, 16'hFFFE);

        // Reload with random load_valid gaps
        PC = 8'h00;
        pulse_reload();
        chk("gap_ready",       {31'h0, load_ready}, 32'h1);
        for (int i = 1; i <= 6; i++)
            send_byte(8'(i), (i == 6), 1'b1);
        tick();
        chk("gap_loaded",      {31'h0, loaded},     32'h1);
        fetch("gap_w0",        8'h00, 16'h0201);
        fetch("gap_w1",        8'h01, 16'h0403);
        fetch("gap_w2",        8'h02, 16'h0605);
        fetch("gap_w3_kept",   8'h03, 16'h0706);

        // Reset after one byte: half word discarded, restart at word 0
        pulse_reload();
        send_byte(8'hEE, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_cpu_rst",  {31'h0, cpu_reset},  32'h1);
        chk("midrst_waddr",    {24'h0, dut.u_boot.waddr}, 32'h0);
        tick();
        reset = 1'b0;
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        tick();
        fetch("midrst_w0",     8'h00, 16'h2211);
        fetch("midrst_w1_kept",8'h01, 16'h0403);

        // Async reset from RUN takes effect without a clock edge; memories retained
        #3;
        reset = 1'b1;
        #1;
        chk("async_loaded",    {31'h0, loaded},     32'h0);
        chk("async_cpu_rst",   {31'h0, cpu_reset},  32'h1);
        chk("async_instr0",    {16'h0, Instr},      32'h0);
        chk("rst_dmem_kept",   {24'h0, ReadData},   32'h5A);
        tick();
        reset = 1'b0;
        send_byte(8'h99, 1'b1, 1'b0);
        tick();
        fetch("rst_imem_kept", 8'h01, 16'h0403);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
